base_fifo_vr: RTL
=================

Name: base_fifo_vr

Overview:
Parameterised synchronous FIFO with a valid/ready handshake on both the load side and the unload side.
- Where enable-gated registers capture data, this block is the consumer end: it accepts words only when it asserts ready, and presents them downstream until they are taken.
- Used as the standard elastic buffer between pipeline stages in the base cell library.
- First-word fall-through: the head entry is always visible on o_d.

Parameters:
width, 8, data word width in bits; bit order [0:width-1]
depth, 4, number of entries; must be a power of two and at least 2
rstv, 0, reset value of every storage entry, width bits

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-high reset
i_v  input  1  load side: input word valid
i_r  output  1  load side: FIFO can accept a word
i_d  input  width  load side: input data
o_v  output  1  unload side: head word valid
o_r  input  1  unload side: downstream takes the word this cycle
o_d  output  width  unload side: head data
count  output  clog2(depth)+1  number of occupied entries
full  output  1  count == depth
empty  output  1  count == 0

Behaviour:
- Reset state (asynchronous, immediate):
  - wr_ptr = rd_ptr = 0 and count = 0.
  - All entries = rstv, so o_d = rstv.
  - o_v = 0, empty = 1, full = 0.
  - i_r = 0 while reset is high; i_r = 1 from the first clk edge after reset falls.
- Push = i_v & i_r. Pop = o_v & o_r. Both are evaluated at posedge clk.
- i_r = ~full, gated by a registered "out of reset" flag. i_r has no combinational dependence on o_r, so a full FIFO with a simultaneous pop still refuses the push that cycle.
- o_v = ~empty. o_d = mem[rd_ptr], read combinationally from registered storage.
- Latency: a word pushed at edge N is visible with o_v = 1 after edge N. Minimum occupancy is 1 cycle. There is no combinational i_d-to-o_d bypass.
- Push only: mem[wr_ptr] <= i_d, wr_ptr++, count++.
- Pop only: rd_ptr++, count--.
- Push and pop together (neither empty nor full): both pointers advance and count is unchanged.
- Push and pop together when empty: cannot occur, because o_v = 0 when empty.
- Pointers are clog2(depth) bits wide and wrap modulo depth naturally, with no special wrap logic.
- full and empty are decoded from count only.
- Protocol checks:
  - i_v may drop without a handshake. Data is captured only on push.
  - Once o_v = 1, o_v and o_d hold stable until a pop occurs.
- Reset asserted mid-operation discards all contents immediately, even with a push or pop in flight.
- Illegal parameter (depth not a power of two, or depth < 2): elaboration error.

Decomposition:
- Package base_fifo_pkg holds:
  - the constant function clog2;
  - localparam helpers for pointer width and count width.
- One sub-module, base_fifo_ptr: a wrapping pointer register with asynchronous reset to 0 and an increment enable. It is instantiated twice, for wr_ptr and rd_ptr.
- Storage array, count and the i_r gating stay in base_fifo_vr.

Test Plan:
1. Reset with depth=4, width=8, rstv=8'hA5 → o_v=0, empty=1, full=0, count=0, o_d=A5, i_r=0 during reset and 1 one edge after release.
2. Push 11, 22, 33, 44 with o_r=0 → count 1..4, full=1 and i_r=0 after the 4th edge; a 5th push with 55 is ignored; o_d stays 11.
3. From full, hold o_r=1 and i_v=1 with i_d=55 → first edge: pop only (count 3, o_d=22); next edge: push and pop together (count 3); drain order is 22, 33, 44, 55.
4. Stream with i_v=o_r=1 for 10 cycles over data 0..9 → count stays at 1 after the first edge; output sequence is 0..9 with no gaps; pointers wrap twice.
5. Push 3 words, then assert reset between edges → o_v drops immediately, count=0, o_d=rstv; after release a push of 77 appears alone on o_d.
6. Randomised o_r back-pressure with 100 words → scoreboard shows exact in-order delivery and o_d stable while o_v & ~o_r.

Source files
------------

// File: rtl/base_fifo_pkg.sv
// Shared sizing helpers for the valid/ready FIFO and its pointer registers.
package base_fifo_pkg;

    localparam int MIN_DEPTH = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ptr_w(input int d);
        return clog2(d);
    endfunction

    function automatic int cnt_w(input int d);
        return clog2(d) + 1;
    endfunction

    function automatic bit depth_ok(input int d);
        return (d >= MIN_DEPTH) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/base_fifo_ptr.sv
// Wrapping pointer register; natural binary overflow provides the modulo-depth wrap.
module base_fifo_ptr
    import base_fifo_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/base_fifo_vr.sv
// First-word fall-through FIFO with valid/ready on both sides; head entry always drives o_d.
module base_fifo_vr
    import base_fifo_pkg::*;
#(
    parameter int               width = 8,
    parameter int               depth = 4,
    parameter logic [0:width-1] rstv  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_v,
    output logic                    i_r,
    input  logic [0:width-1]        i_d,
    output logic                    o_v,
    input  logic                    o_r,
    output logic [0:width-1]        o_d,
    output logic [cnt_w(depth)-1:0] count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = ptr_w(depth);
    localparam int CW = cnt_w(depth);

    if (!depth_ok(depth)) begin : g_bad_depth
        $error("base_fifo_vr: depth must be a power of two and at least 2");
    end

    logic [0:width-1] mem_q [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             rdy_q;
    logic             push;
    logic             pop;

    assign push = i_v & i_r;
    assign pop  = o_v & o_r;

    base_fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    base_fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // rdy_q keeps i_r low until the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            rdy_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) mem_q[i] <= rstv;
        end else if (push) begin
            mem_q[wr_ptr] <= i_d;
        end
    end

    assign full  = (count_q == CW'(depth));
    assign empty = (count_q == '0);
    assign i_r   = rdy_q & ~full;
    assign o_v   = ~empty;
    assign o_d   = mem_q[rd_ptr];
    assign count = count_q;

endmodule
